// File: rtl/aer_pkg.sv
// Shared definitions for the dual-rail AER link (transmitter and receiver).
// Rail encoding is {ONE, ZERO}.
package aer_pkg;

    localparam int ADDR_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RTZ  = 2'd2
    } aer_state_t;

    localparam logic [1:0] SYM_SPACER = 2'b00;
    localparam logic [1:0] SYM_ZERO   = 2'b01;
    localparam logic [1:0] SYM_ONE    = 2'b10;
    localparam logic [1:0] SYM_DELIM  = 2'b11;

    // Data symbol for one address (or parity) bit.
    function automatic logic [1:0] sym_of_bit(input logic b);
        return b ? SYM_ONE : SYM_ZERO;
    endfunction

endpackage

// File: rtl/aer_if.sv
// Event-source handshake plus dual-rail link signals of the AER transmitter.
// slave: the transmitter's view; master: the event source / link partner view.
interface aer_if
    import aer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) ();

    logic              ev_valid;
    logic [ADDR_W-1:0] ev_addr;
    logic              ev_ready;
    logic              ACK;
    logic              ZERO_OUT;
    logic              ONE_OUT;
    logic              busy;
    logic              frame_done;

    modport master (
        output ev_valid, ev_addr, ACK,
        input  ev_ready, ZERO_OUT, ONE_OUT, busy, frame_done
    );

    modport slave (
        input  ev_valid, ev_addr, ACK,
        output ev_ready, ZERO_OUT, ONE_OUT, busy, frame_done
    );

endinterface

// File: rtl/aer_sync2.sv
// Two-flop synchroniser for a single asynchronous level (link ACK).
// Shared with the AER receiver.
module aer_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Resample the asynchronous input twice before anything consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/aer_transmitter.sv
// Dual-rail AER transmitter: one accepted address becomes a frame
// Fs, addr MSB..LSB, [parity], Fe, each symbol a 4-phase RTZ handshake on ACK.
// Build option: define AER_PARITY_EN to send an even-parity data symbol
// between the LSB and Fe.
//
// state | meaning
// IDLE  | rails at spacer, ev_ready high, waiting for an event
// SEND  | current symbol on the rails, waiting for ack_s high
// RTZ   | rails at spacer, waiting for ack_s low
module aer_transmitter
    import aer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input logic  clk,
    input logic  reset,
    aer_if.slave bus
);

`ifdef AER_PARITY_EN
    localparam int N_SYM = ADDR_W + 3;
`else
    localparam int N_SYM = ADDR_W + 2;
`endif
    localparam int CNT_W = $clog2(N_SYM);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SYM - 1);
    localparam logic [CNT_W-1:0] LSB_IDX  = CNT_W'(ADDR_W);
`ifdef AER_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_IDX  = CNT_W'(ADDR_W + 1);
`endif

    aer_state_t        r_state;
    aer_state_t        w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [CNT_W-1:0]  w_sel_cnt;
    logic [ADDR_W-1:0] r_shift;
    logic [ADDR_W-1:0] w_shift_nx;
    logic [1:0]        r_rails;
    logic [1:0]        w_sym;
    logic              r_armed;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_rdy_en;
    logic              w_ack_s;
    logic              w_accept;
    logic              w_send_done;
    logic              w_rtz_done;
    logic              w_last;
    logic              w_sel_msb;
`ifdef AER_PARITY_EN
    logic              r_parity;
`endif

    aer_sync2 u_ack_sync (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (bus.ACK),
        .o_q   (w_ack_s)
    );

    // r_armed records that ack_s was seen low during this SEND, so an ACK
    // already high when the symbol goes out cannot close it early.
    assign w_accept    = r_rdy_en && (r_state == IDLE) && bus.ev_valid;
    assign w_send_done = (r_state == SEND) && r_armed && w_ack_s;
    assign w_rtz_done  = (r_state == RTZ) && !w_ack_s;
    assign w_last      = (r_cnt == LAST_IDX);
    assign w_cnt_nx    = r_cnt + 1'b1;
    // The Fs slot consumes no address bit, so shift only after data symbols.
    assign w_shift_nx  = (r_cnt == '0) ? r_shift : (r_shift << 1);

    // Symbol decode: in SEND for the current slot, in RTZ for the slot that
    // follows, so the next symbol lands on the rails on the RTZ exit edge.
    always_comb begin
        w_sel_cnt = r_cnt;
        w_sel_msb = r_shift[ADDR_W-1];
        if (r_state == RTZ) begin
            w_sel_cnt = w_cnt_nx;
            w_sel_msb = w_shift_nx[ADDR_W-1];
        end
        w_sym = SYM_DELIM;
        if ((w_sel_cnt != '0) && (w_sel_cnt <= LSB_IDX)) begin
            w_sym = sym_of_bit(w_sel_msb);
        end
`ifdef AER_PARITY_EN
        else if (w_sel_cnt == PAR_IDX) begin
            w_sym = sym_of_bit(r_parity);
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: if (w_accept)    w_state_nx = SEND;
            SEND: if (w_send_done) w_state_nx = RTZ;
            RTZ:  if (w_rtz_done)  w_state_nx = w_last ? IDLE : SEND;
            default:               w_state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Frame datapath: shift register, symbol counter and registered rails.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_rails <= SYM_SPACER;
            r_armed <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift <= bus.ev_addr;
                        r_cnt   <= '0;
                        r_armed <= 1'b0;
                    end
                end
                SEND: begin
                    if (w_send_done) begin
                        r_rails <= SYM_SPACER;
                        r_armed <= 1'b0;
                    end else begin
                        r_rails <= w_sym;
                        if (!w_ack_s) begin
                            r_armed <= 1'b1;
                        end
                    end
                end
                RTZ: begin
                    if (w_rtz_done && !w_last) begin
                        r_cnt   <= w_cnt_nx;
                        r_shift <= w_shift_nx;
                        r_rails <= w_sym;
                    end
                end
                default: begin
                    r_rails <= SYM_SPACER;
                end
            endcase
        end
    end

`ifdef AER_PARITY_EN
    // Even parity of the accepted address, captured with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^bus.ev_addr;
        end
    end
`endif

    // Status flags: ready enable after reset, busy, frame completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdy_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rdy_en     <= 1'b1;
            r_busy       <= (r_state != IDLE) && (w_state_nx != IDLE);
            r_frame_done <= w_rtz_done && w_last;
        end
    end

    assign bus.ev_ready   = r_rdy_en && (r_state == IDLE);
    assign bus.ZERO_OUT   = r_rails[0];
    assign bus.ONE_OUT    = r_rails[1];
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule

// File: doc/aer_transmitter.md
# aer_transmitter

Transmit end of the team's dual-rail AER link; drives the `ZERO`/`ONE` rails that the receiver consumes and closes each symbol on the receiver's `ACK`. Accepts one address-event per valid/ready handshake. Serialises it as a frame-start symbol, the address bits MSB first and a frame-end symbol. Every symbol is a 4-phase return-to-zero handshake. Sits between the on-chip event source (neuron array arbiter) and the off-chip link pads.

## Interface
- `ADDR_W`, 8: address width in bits; legal range 1–16.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ev_valid`  in  1  event source has an address on `ev_addr`.
- `ev_addr`  in  ADDR_W  event address; sampled only on accept.
- `ev_ready`  out  1  block idle and able to accept.
- `ACK`  in  1  link acknowledge from receiver; asynchronous to `clk`.
- `ZERO_OUT`  out  1  zero rail.
- `ONE_OUT`  out  1  one rail.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse when the final RTZ phase completes.

## Operation
- Symbol encoding on the rails:
  - Data 0 = `ZERO_OUT` only.
  - Data 1 = `ONE_OUT` only.
  - Delimiter = both rails high. The first delimiter is Fs and the last is Fe; the receiver tells them apart by position.
  - Spacer = both rails low.
- Frame: Fs, `ev_addr[ADDR_W-1]` … `ev_addr[0]`, [parity], Fe. Total symbols N = ADDR_W+2, or ADDR_W+3 with parity.
- `ACK` passes through a 2-flop synchroniser (`ack_s`) before use.
- The FSM has three states:
  - IDLE: `ev_ready`=1. On `ev_valid`: load the shift register from `ev_addr`, clear the symbol counter, go to SEND.
  - SEND: drive the current symbol. On `ack_s`=1, drive the spacer and go to RTZ.
  - RTZ: on `ack_s`=0, if the counter equals N-1 then pulse `frame_done` and go to IDLE; otherwise increment the counter, shift, and go to SEND.
- Rails are registered outputs and only ever change from spacer to symbol or from symbol to spacer; they never go directly from one symbol to another.
- `ev_addr` changes after accept do not affect the frame in progress.
- A stalled `ACK` (held high or held low) holds the current phase indefinitely; the block has no timeout.
- `ACK` already high when a frame starts: the block stays in SEND with the symbol driven until `ack_s` is seen high. It does not skip RTZ.
- Reset (asynchronous, any time including mid-frame): rails=0, `ev_ready`=0 while reset is asserted, `busy`=0, `frame_done`=0, synchroniser cleared, FSM=IDLE. The partial frame is abandoned and the receiver must resynchronise on the next Fs.

## Timing
- Reset values: `ZERO_OUT`=0, `ONE_OUT`=0, `busy`=0, `frame_done`=0. `ev_ready` is 1 from the first clock edge after reset deasserts.
- Accept at edge k: Fs on the rails after edge k+1, and `busy`=1 from edge k+1.
- `ACK` rising to rails dropping: 3 cycles (2 synchroniser + 1 FSM).
- `ACK` falling to next symbol on the rails: 3 cycles.
- With an instant-ack receiver, each symbol takes 6 cycles. The frame takes 6·N cycles from first assertion to `frame_done`.
- `frame_done` coincides with the return to IDLE: `ev_ready`=1 in that cycle and `busy`=0.
- Back-to-back: an event can be accepted in the `frame_done` cycle, giving the next Fs one cycle later.

## Configuration
- `AER_PARITY_EN` defined: an even-parity bit (XOR of all address bits) is sent as a data symbol between the LSB and Fe, so N = ADDR_W+3.
- `AER_PARITY_EN` undefined: no parity symbol, N = ADDR_W+2, and the parity logic is absent.

## Structure
- Shared package `aer_pkg` holds:
  - the state enum (IDLE/SEND/RTZ);
  - the symbol encoding constants SYM_ZERO=2'b01, SYM_ONE=2'b10, SYM_DELIM=2'b11, SYM_SPACER=2'b00, as {ONE,ZERO};
  - the default ADDR_W.
- One sub-module, `aer_sync2`: the 2-flop synchroniser with asynchronous active-low reset. The receiver reuses it.

## Test plan
- ADDR_W=8, `ev_addr`=0xA5, zero-delay ack responder → rail sequence 11,10,01,10,01,01,10,01,10,11 as {ONE,ZERO}, each separated by 00; `frame_done` 60 cycles after the first assertion.
- Same frame with `AER_PARITY_EN` defined and `ev_addr`=0xA5 → ZERO symbol inserted before Fe. With `ev_addr`=0xA4 → ONE symbol inserted before Fe.
- `ev_valid` held high with a new address during a frame → `ev_ready`=0 throughout and the second frame starts one cycle after `frame_done`.
- Responder delays `ACK` by 50 cycles → symbol held stable for the whole wait; spacer exactly 3 cycles after `ACK` rises.
- `reset` asserted during the 4th data symbol → rails 00 immediately (before the next edge). After release, a new event produces a clean Fs-first frame.
- `ACK` held high at accept → Fs driven and held; nothing further happens until `ACK` toggles low and then high again.
